// File: rtl/n64_vinfo_lock.sv
// n64_vinfo_lock: qualifies vmode/480i over several frames and commits them on frame edges.
// Optional line watchdog enabled by defining VINFO_LOCK_TIMEOUT_EN.
module n64_vinfo_lock #(
  parameter int LOCK_FRAMES   = 3,
  parameter int UNLOCK_FRAMES = 2,
  parameter int TIMEOUT_LINES = 700
) (
  input  logic       VCLK,
  input  logic       RST,
  input  logic       nDSYNC,
  input  logic [3:0] Sync_pre,
  input  logic [3:0] Sync_cur,
  input  logic [3:0] vinfo_i,
  output logic       vmode_o,
  output logic       n64_480i_o,
  output logic       locked_o,
  output logic       update_o,
  output logic       timeout_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);

  logic       frame_evt;
  logic       line_evt;
  logic       frame_evt_d;
  logic       tmo;
  logic       act;
  logic [1:0] sample;
  logic [1:0] cand;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;
  logic       unused_bits;

  assign frame_evt = !nDSYNC && !Sync_pre[3] && Sync_cur[3];
  assign line_evt  = !nDSYNC && !Sync_pre[1] && Sync_cur[1];
  assign sample    = vinfo_i[1:0];
  assign match_inc = (match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1;
  assign miss_inc  = (miss_cnt == 4'd15) ? 4'd15 : miss_cnt + 4'd1;
  assign unused_bits = ^{vinfo_i[3:2], Sync_pre[2], Sync_pre[0],
                         Sync_cur[2], Sync_cur[0], line_evt};

`ifdef VINFO_LOCK_TIMEOUT_EN
  localparam logic [9:0] TO_N = 10'(TIMEOUT_LINES);

  logic [9:0] line_cnt;
  logic [9:0] line_inc;

  assign line_inc = (line_cnt == 10'd1023) ? 10'd1023 : line_cnt + 10'd1;
  assign tmo      = line_evt && !frame_evt && (line_inc >= TO_N);

  // Line watchdog counter: cleared by frame edges and by its own expiry.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      line_cnt <= 10'd0;
    end else if (frame_evt) begin
      line_cnt <= 10'd0;
    end else if (line_evt) begin
      line_cnt <= tmo ? 10'd0 : line_inc;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Watchdog expiry discards any sample landing on the same cycle.
  assign act = frame_evt_d && !tmo;

  // Frame-edge delay, lock FSM, candidate tracking and committed outputs.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      frame_evt_d <= 1'b0;
      vmode_o     <= 1'b0;
      n64_480i_o  <= 1'b1;
      locked_o    <= 1'b0;
      update_o    <= 1'b0;
      timeout_o   <= 1'b0;
      state_o     <= SEARCH;
      cand        <= 2'b01;
      match_cnt   <= 4'd0;
      miss_cnt    <= 4'd0;
    end else begin
      frame_evt_d <= frame_evt;
      update_o    <= 1'b0;
      timeout_o   <= 1'b0;
      if (tmo) begin
        state_o   <= SEARCH;
        locked_o  <= 1'b0;
        match_cnt <= 4'd0;
        miss_cnt  <= 4'd0;
        timeout_o <= 1'b1;
      end else if (act) begin
        case (state_o)
          SEARCH: begin
            cand      <= sample;
            match_cnt <= 4'd1;
            if (LOCK_N <= 4'd1) begin
              {vmode_o, n64_480i_o} <= sample;
              locked_o <= 1'b1;
              miss_cnt <= 4'd0;
              update_o <= 1'b1;
              state_o  <= LOCKED;
            end else begin
              state_o <= VERIFY;
            end
          end
          VERIFY: begin
            if (sample == cand) begin
              match_cnt <= match_inc;
              if (match_inc >= LOCK_N) begin
                {vmode_o, n64_480i_o} <= cand;
                locked_o <= 1'b1;
                miss_cnt <= 4'd0;
                update_o <= 1'b1;
                state_o  <= LOCKED;
              end
            end else begin
              cand      <= sample;
              match_cnt <= 4'd1;
            end
          end
          LOCKED: begin
            if (sample == cand) begin
              miss_cnt <= 4'd0;
            end else begin
              miss_cnt <= miss_inc;
              if (miss_inc >= UNLOCK_N) begin
                locked_o  <= 1'b0;
                cand      <= sample;
                match_cnt <= 4'd1;
                state_o   <= VERIFY;
              end
            end
          end
          default: begin
            state_o <= SEARCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n64_vinfo_lock.sv
// tb_n64_vinfo_lock: directed checks of lock/unlock, sync gating, reset and watchdog.
// Define VINFO_LOCK_TIMEOUT_EN to exercise the watchdog with TIMEOUT_LINES=8.
module tb_n64_vinfo_lock;

`ifdef VINFO_LOCK_TIMEOUT_EN
  localparam int TL = 8;
`else
  localparam int TL = 700;
`endif

  logic       VCLK = 1'b0;
  logic       RST = 1'b1;
  logic       nDSYNC = 1'b0;
  logic [3:0] Sync_pre = 4'hF;
  logic [3:0] Sync_cur = 4'hF;
  logic [3:0] vinfo_i = 4'h0;
  logic       vmode_o;
  logic       n64_480i_o;
  logic       locked_o;
  logic       update_o;
  logic       timeout_o;
  logic [1:0] state_o;

  int checks = 0;
  int failures = 0;

  n64_vinfo_lock #(
    .LOCK_FRAMES(3),
    .UNLOCK_FRAMES(2),
    .TIMEOUT_LINES(TL)
  ) dut (
    .VCLK(VCLK),
    .RST(RST),
    .nDSYNC(nDSYNC),
    .Sync_pre(Sync_pre),
    .Sync_cur(Sync_cur),
    .vinfo_i(vinfo_i),
    .vmode_o(vmode_o),
    .n64_480i_o(n64_480i_o),
    .locked_o(locked_o),
    .update_o(update_o),
    .timeout_o(timeout_o),
    .state_o(state_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One frame edge; returns at the negedge where a commit would be visible.
  task automatic frame(input logic [1:0] v);
    @(negedge VCLK);
    vinfo_i  = {2'b00, v};
    Sync_pre = 4'b0111;
    @(negedge VCLK);
    Sync_pre = 4'hF;
    @(negedge VCLK);
  endtask

  task automatic line();
    @(negedge VCLK);
    Sync_pre = 4'b1101;
    @(negedge VCLK);
    Sync_pre = 4'hF;
  endtask

  initial begin
    logic seen;

    @(negedge VCLK);
    RST = 1'b0;
    check("rst_vmode", vmode_o, 0);
    check("rst_480i", n64_480i_o, 1);
    check("rst_locked", locked_o, 0);
    check("rst_update", update_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_state", state_o, 0);

    frame(2'b00);
    check("t1_f1_state", state_o, 1);
    frame(2'b00);
    check("t1_f2_locked", locked_o, 0);
    @(negedge VCLK);
    vinfo_i  = 4'h0;
    Sync_pre = 4'b0111;
    @(negedge VCLK);
    Sync_pre = 4'hF;
    check("t1_upd_early", update_o, 0);
    @(negedge VCLK);
    check("t1_upd", update_o, 1);
    check("t1_locked", locked_o, 1);
    check("t1_vmode", vmode_o, 0);
    check("t1_480i", n64_480i_o, 0);
    check("t1_state", state_o, 2);
    @(negedge VCLK);
    check("t1_upd_clr", update_o, 0);

    frame(2'b10);
    check("t2_miss1_locked", locked_o, 1);
    check("t2_miss1_upd", update_o, 0);
    frame(2'b00);
    check("t2_back_locked", locked_o, 1);
    frame(2'b10);
    check("t2_m1_locked", locked_o, 1);
    frame(2'b10);
    check("t2_unlock", locked_o, 0);
    check("t2_unlock_state", state_o, 1);
    check("t2_hold_vmode", vmode_o, 0);
    check("t2_hold_480i", n64_480i_o, 0);
    frame(2'b10);
    check("t2_v2_locked", locked_o, 0);
    frame(2'b10);
    check("t2_relock_upd", update_o, 1);
    check("t2_relock", locked_o, 1);
    check("t2_vmode", vmode_o, 1);
    check("t2_480i", n64_480i_o, 0);

    seen = 1'b0;
    @(negedge VCLK);
    nDSYNC   = 1'b1;
    vinfo_i  = 4'h3;
    Sync_pre = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge VCLK);
      if (i == 1) Sync_pre = 4'hF;
      if (i == 2) Sync_pre = 4'b0101;
      if (update_o) seen = 1'b1;
    end
    Sync_pre = 4'hF;
    nDSYNC   = 1'b0;
    repeat (2) begin
      @(negedge VCLK);
      if (update_o) seen = 1'b1;
    end
    check("t4_no_upd", seen, 0);
    check("t4_state", state_o, 2);
    check("t4_locked", locked_o, 1);
    frame(2'b11);
    check("t4_miss_once", locked_o, 1);
    frame(2'b10);
    check("t4_ok", locked_o, 1);

    frame(2'b00);
    frame(2'b00);
    check("t5_state", state_o, 1);
    frame(2'b00);
    check("t5_verify", state_o, 1);
    @(negedge VCLK);
    RST = 1'b1;
    @(negedge VCLK);
    RST = 1'b0;
    check("t5_vmode", vmode_o, 0);
    check("t5_480i", n64_480i_o, 1);
    check("t5_locked", locked_o, 0);
    check("t5_update", update_o, 0);
    check("t5_state", state_o, 0);

    frame(2'b00);
    frame(2'b00);
    frame(2'b01);
    check("t3_restart_state", state_o, 1);
    check("t3_restart_locked", locked_o, 0);
    frame(2'b01);
    check("t3_m2_locked", locked_o, 0);
    frame(2'b01);
    check("t3_lock_upd", update_o, 1);
    check("t3_locked", locked_o, 1);
    check("t3_480i", n64_480i_o, 1);

    frame(2'b11);
    frame(2'b11);
    frame(2'b11);
    frame(2'b11);
    check("t6_locked", locked_o, 1);
    check("t6_vmode", vmode_o, 1);
    check("t6_480i", n64_480i_o, 1);
    repeat (7) line();
    check("t6_early_to", timeout_o, 0);
    check("t6_early_lock", locked_o, 1);
    line();
    seen = timeout_o;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge VCLK);
      seen = timeout_o;
    end
`ifdef VINFO_LOCK_TIMEOUT_EN
    check("t6_to_pulse", seen, 1);
    @(negedge VCLK);
    check("t6_to_clr", timeout_o, 0);
    check("t6_locked", locked_o, 0);
    check("t6_state", state_o, 0);
`else
    check("t6_no_to", seen, 0);
    check("t6_still_lock", locked_o, 1);
    check("t6_state", state_o, 2);
`endif
    check("t6_hold_vmode", vmode_o, 1);
    check("t6_hold_480i", n64_480i_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
